// File: rtl/game_player.sv
// Match controller for a step-counter game: loads a seed, cycles step commands, ends on GAMEOVER or timeout.
// Optional per-match WINNER/LOSER tallies are built only when GAME_PLAYER_SCOREBOARD_EN is defined.
module game_player #(
  parameter int WIDTH      = 4,
  parameter int MAX_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_value,
  input  logic [3:0]       phase_len,
  input  logic             WINNER,
  input  logic             LOSER,
  input  logic             GAMEOVER,
  input  logic [1:0]       WHO,
  output logic             INIT,
  output logic [1:0]       control,
  output logic [WIDTH-1:0] load_value,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result,
  output logic             timeout,
  output logic [3:0]       win_seen,
  output logic [3:0]       lose_seen
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [9:0] CYC_LAST = 10'(MAX_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] phase;
  logic [1:0] step;
  logic [9:0] cyc;
  logic       phase_end;
  logic       cyc_end;

  // phase_len of 0 wraps to 15 here, giving a 16-cycle phase for free
  assign phase_end = (phase == phase_len - 4'd1);
  assign cyc_end   = (cyc == CYC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (GAMEOVER || cyc_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    INIT    = (state == LOAD);
    busy    = (state == LOAD) || (state == RUN);
    done    = (state == DONE);
    control = (state == RUN) ? step : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_value <= '0;
      result     <= 2'b00;
      timeout    <= 1'b0;
      phase      <= 4'd0;
      step       <= 2'b00;
      cyc        <= 10'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          load_value <= seed_value;
          result     <= 2'b00;
          timeout    <= 1'b0;
          phase      <= 4'd0;
          step       <= 2'b00;
          cyc        <= 10'd0;
        end
        RUN: begin
          cyc <= cyc + 10'd1;
          if (phase_end) begin
            phase <= 4'd0;
            step  <= step + 2'd1;
          end else begin
            phase <= phase + 4'd1;
          end
          // a real game result beats a coincident timeout
          if (GAMEOVER) begin
            result  <= WHO;
            timeout <= 1'b0;
          end else if (cyc_end) begin
            result  <= 2'b00;
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GAME_PLAYER_SCOREBOARD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_seen  <= 4'd0;
      lose_seen <= 4'd0;
    end else if (state == IDLE && start) begin
      win_seen  <= 4'd0;
      lose_seen <= 4'd0;
    end else if (state == RUN) begin
      if (WINNER && win_seen != 4'd15)  win_seen  <= win_seen + 4'd1;
      if (LOSER  && lose_seen != 4'd15) lose_seen <= lose_seen + 4'd1;
    end
  end
`else
  logic unused_events;
  assign unused_events = WINNER ^ LOSER;
  assign win_seen  = 4'd0;
  assign lose_seen = 4'd0;
`endif

endmodule

// File: tb/tb_game_player.sv
// Directed bench for game_player: a default instance plus a MAX_CYCLES=20 instance for timeout cases.
module tb_game_player;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start_b = 1'b0;
  logic [3:0] seed_value = 4'd0;
  logic [3:0] phase_len = 4'd2;
  logic       winner = 1'b0, loser = 1'b0;
  logic       gameover = 1'b0, gameover_b = 1'b0;
  logic [1:0] who = 2'b00;

  logic       a_init, a_busy, a_done, a_timeout;
  logic [1:0] a_control, a_result;
  logic [3:0] a_load_value, a_win, a_lose;
  logic       b_init, b_busy, b_done, b_timeout;
  logic [1:0] b_control, b_result;
  logic [3:0] b_load_value, b_win, b_lose;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  game_player dut_a (
    .clk(clk), .rst(rst), .start(start), .seed_value(seed_value), .phase_len(phase_len),
    .WINNER(winner), .LOSER(loser), .GAMEOVER(gameover), .WHO(who),
    .INIT(a_init), .control(a_control), .load_value(a_load_value), .busy(a_busy),
    .done(a_done), .result(a_result), .timeout(a_timeout), .win_seen(a_win), .lose_seen(a_lose)
  );

  game_player #(.WIDTH(4), .MAX_CYCLES(20)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .seed_value(seed_value), .phase_len(phase_len),
    .WINNER(winner), .LOSER(loser), .GAMEOVER(gameover_b), .WHO(who),
    .INIT(b_init), .control(b_control), .load_value(b_load_value), .busy(b_busy),
    .done(b_done), .result(b_result), .timeout(b_timeout), .win_seen(b_win), .lose_seen(b_lose)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_ctrl [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
`ifdef GAME_PLAYER_SCOREBOARD_EN
  localparam logic [3:0] EXP_WIN = 4'd3, EXP_LOSE = 4'd15;
`else
  localparam logic [3:0] EXP_WIN = 4'd0, EXP_LOSE = 4'd0;
`endif

  initial begin
    // reset values before any clock edge
    #2;
    check("rst_init", a_init, 0);
    check("rst_control", a_control, 0);
    check("rst_load_value", a_load_value, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_result", a_result, 0);
    check("rst_timeout", a_timeout, 0);
    check("rst_win", a_win, 0);
    check("rst_lose", a_lose, 0);
    tick();
    rst = 1'b0;
    tick();

    // match 1: seed 1, phase_len 2, GAMEOVER WHO=01 at RUN cycle 37
    seed_value = 4'd1; phase_len = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("load_init", a_init, 1);
    check("load_value", a_load_value, 1);
    check("load_busy", a_busy, 1);
    check("load_control", a_control, 0);
    tick();
    check("run1_init", a_init, 0);
    for (int k = 1; k <= 37; k++) begin
      if (k <= 9) check($sformatf("ctrl_pl2_c%0d", k), a_control, exp_ctrl[k-1]);
      if (k == 16) begin
        check("start_in_run_init", a_init, 0);
        check("start_in_run_busy", a_busy, 1);
      end
      winner   = (k >= 10 && k <= 12);
      loser    = (k >= 10 && k <= 26);
      start    = (k == 15);
      gameover = (k == 37);
      who      = 2'b01;
      tick();
    end
    winner = 1'b0; loser = 1'b0; start = 1'b0; gameover = 1'b0;
    check("gover_done", a_done, 1);
    check("gover_result", a_result, 2'b01);
    check("gover_timeout", a_timeout, 0);
    check("gover_busy", a_busy, 0);
    check("sb_win", a_win, EXP_WIN);
    check("sb_lose", a_lose, EXP_LOSE);
    tick();
    check("idle_done_low", a_done, 0);
    check("idle_result_held", a_result, 2'b01);

    // GAMEOVER in IDLE must not disturb anything
    gameover = 1'b1; who = 2'b11;
    tick();
    tick();
    gameover = 1'b0;
    check("idle_gover_result", a_result, 2'b01);
    check("idle_gover_done", a_done, 0);
    check("idle_gover_busy", a_busy, 0);

    // match 2: phase_len 0 means 16-cycle phases
    seed_value = 4'd5; phase_len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("m2_load_value", a_load_value, 5);
    check("m2_result_clr", a_result, 0);
    check("m2_win_clr", a_win, 0);
    check("m2_lose_clr", a_lose, 0);
    tick();
    for (int k = 1; k <= 33; k++) begin
      if (k == 1)  check("pl16_c1", a_control, 0);
      if (k == 16) check("pl16_c16", a_control, 0);
      if (k == 17) check("pl16_c17", a_control, 1);
      if (k == 32) check("pl16_c32", a_control, 1);
      if (k == 33) check("pl16_c33", a_control, 2);
      gameover = (k == 33);
      who = 2'b10;
      tick();
    end
    gameover = 1'b0;
    check("m2_done", a_done, 1);
    check("m2_result", a_result, 2'b10);
    tick();

    // dut_b: pure timeout after 20 RUN cycles
    phase_len = 4'd2; who = 2'b11; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    for (int k = 1; k <= 20; k++) begin
      if (k == 20) check("to_busy_c20", b_busy, 1);
      tick();
    end
    check("to_done", b_done, 1);
    check("to_timeout", b_timeout, 1);
    check("to_result", b_result, 0);
    tick();
    check("to_timeout_held", b_timeout, 1);

    // dut_b: GAMEOVER on the timeout cycle wins
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("to2_timeout_clr", b_timeout, 0);
    tick();
    for (int k = 1; k <= 20; k++) begin
      gameover_b = (k == 20);
      tick();
    end
    gameover_b = 1'b0;
    check("to2_done", b_done, 1);
    check("to2_timeout", b_timeout, 0);
    check("to2_result", b_result, 2'b11);
    tick();

    // asynchronous reset mid-RUN
    seed_value = 4'd9; phase_len = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_control", a_control, 2);
    check("pre_rst_busy", a_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_control", a_control, 0);
    check("arst_busy", a_busy, 0);
    check("arst_init", a_init, 0);
    check("arst_load_value", a_load_value, 0);
    check("arst_result", a_result, 0);
    check("arst_timeout", a_timeout, 0);
    check("arst_done", a_done, 0);
    tick();
    check("arst_no_done", a_done, 0);
    rst = 1'b0;
    tick();
    check("post_rst_done", a_done, 0);
    check("post_rst_busy", a_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
